// File: rtl/light_ctrl_selftest_if.sv
// Handshake and switch/light signals between the self-test engine and its driver side.
interface light_ctrl_selftest_if;
  logic       start;
  logic       f;
  logic       x1;
  logic       x2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;

  // Board side: requests passes, supplies f, observes results
  modport master (
    output start, f,
    input  x1, x2, busy, done, pass, fail_vec
  );

  // Self-test engine side
  modport slave (
    input  start, f,
    output x1, x2, busy, done, pass, fail_vec
  );
endinterface

// File: rtl/light_ctrl_selftest.sv
// Self-test engine for the two-switch light circuit: walks {x1,x2} through
// 00,01,10,11, samples f after a settle window, reports fail_vec and pass.
module light_ctrl_selftest #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter logic [3:0]  EXP_TT        = 4'b0110
) (
  input logic                  clk,
  input logic                  rst,
  light_ctrl_selftest_if.slave bus
);

  // A zero settle time still needs one clock for f to propagate
  localparam int unsigned    SETTLE   = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             pass_q, pass_nxt;
  logic [3:0]       fail_q, fail_nxt;
  logic             miss;

  // f disagrees with the expected truth table for the vector being driven
  assign miss = bus.f ^ EXP_TT[idx];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath/output next values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    pass_nxt  = pass_q;
    fail_nxt  = fail_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          fail_nxt  = 4'b0000;
          pass_nxt  = 1'b0;
        end
      end

      RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          fail_nxt[idx] = fail_q[idx] | miss;
          if (idx == 2'd3) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            idx_nxt   = 2'd0;
            pass_nxt  = ~|fail_nxt;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        idx_nxt   = 2'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 2'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 4'b0000;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      pass_q <= pass_nxt;
      fail_q <= fail_nxt;
    end
  end

  // The vector index register is the switch drive ({x1,x2}, x1 is MSB)
  assign bus.x1       = idx[1];
  assign bus.x2       = idx[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_light_ctrl_selftest.sv
// Bench for light_ctrl_selftest: a truth-table light circuit model feeds f,
// results and per-cycle switch sequencing are checked against a rule-based model.
module tb_light_ctrl_selftest;

  localparam int unsigned S   = 4;
  localparam logic [3:0]  EXP = 4'b0110;
  localparam int          P   = 4 * S + 2;   // accept-to-accept period with start held

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cut_tt;

  int checks   = 0;
  int failures = 0;

  light_ctrl_selftest_if bus ();

  light_ctrl_selftest #(
    .SETTLE_CYCLES(S),
    .CNT_W        (8),
    .EXP_TT       (EXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Circuit under test modelled as a truth table indexed by {x1,x2}
  assign bus.f = cut_tt[{bus.x1, bus.x2}];

  typedef struct {
    logic [3:0] tt;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector i fails exactly when the circuit's output for input i differs from the expectation
  function automatic logic [3:0] model_fail(input logic [3:0] tt);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (tt[i] != EXP[i]);
    return r;
  endfunction

  task automatic check_idle_zero(input string name);
    check(name, 32'({bus.busy, bus.done, bus.pass, bus.x1, bus.x2, bus.fail_vec}), 32'd0);
  endtask

  // One pass: start asserted for one accepting edge, optional extra start pulse at
  // cycle pulse_at; switch sequence and done timing checked per cycle.
  task automatic run_pass(input logic [3:0] tt, input int pulse_at,
                          output logic [3:0] fv, output logic ps);
    cut_tt = tt;
    fv = 4'hx;
    ps = 1'bx;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4 * S + 2; k++) begin
      @(negedge clk);
      if (k < 4 * S) begin
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_x", 32'({bus.x1, bus.x2}), 32'(k / S));
        check("run_done", 32'(bus.done), 32'd0);
      end else if (k == 4 * S) begin
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_x", 32'({bus.x1, bus.x2}), 32'd0);
        fv = bus.fail_vec;
        ps = bus.pass;
      end else begin
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_done", 32'(bus.done), 32'd0);
      end
      bus.start = (k == pulse_at);
    end
    bus.start = 1'b0;
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl [6];
    logic [3:0] fv;
    logic       ps;
    logic [3:0] rtt;
    int         pa;

    tbl[0] = '{tt: 4'b0110, exp_fail: 4'b0000, exp_pass: 1'b1};  // good XOR
    tbl[1] = '{tt: 4'b0000, exp_fail: 4'b0110, exp_pass: 1'b0};  // stuck-at-0
    tbl[2] = '{tt: 4'b1000, exp_fail: 4'b1110, exp_pass: 1'b0};  // AND
    tbl[3] = '{tt: 4'b1111, exp_fail: 4'b1001, exp_pass: 1'b0};  // stuck-at-1
    tbl[4] = '{tt: 4'b1001, exp_fail: 4'b1111, exp_pass: 1'b0};  // XNOR
    tbl[5] = '{tt: 4'b0100, exp_fail: 4'b0010, exp_pass: 1'b0};  // one term lost

    bus.start = 1'b0;
    cut_tt    = EXP;
    rst       = 1'b1;

    // Reset state, before and after release
    #2;
    check_idle_zero("reset_async");
    repeat (2) @(negedge clk);
    check_idle_zero("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_zero("idle_after_reset");
    end

    // Table-driven passes
    for (int i = 0; i < 6; i++) begin
      run_pass(tbl[i].tt, -1, fv, ps);
      check("tbl_fail_vec", 32'(fv), 32'(tbl[i].exp_fail));
      check("tbl_pass", 32'(ps), 32'(tbl[i].exp_pass));
    end

    // Stuck-at-0 results held for 10 clocks after done
    run_pass(4'b0000, -1, fv, ps);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_fail_vec", 32'(bus.fail_vec), 32'(4'b0110));
      check("hold_pass", 32'(bus.pass), 32'd0);
      check("hold_busy", 32'(bus.busy), 32'd0);
    end

    // Start pulse during RUN does nothing; start in DONE cycle is ignored
    run_pass(4'b1000, 5, fv, ps);
    check("runpulse_fail_vec", 32'(fv), 32'(4'b1110));
    run_pass(EXP, 4 * S, fv, ps);
    check("donepulse_pass", 32'(ps), 32'd1);

    // Start held high: back-to-back passes with one DONE and one IDLE cycle between
    cut_tt = EXP;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2 * P; k++) begin
      int ph;
      @(negedge clk);
      ph = k % P;
      check("hold_start_busy", 32'(bus.busy), (ph < 4 * S) ? 32'd1 : 32'd0);
      check("hold_start_done", 32'(bus.done), (ph == 4 * S) ? 32'd1 : 32'd0);
      check("hold_start_x", 32'({bus.x1, bus.x2}), (ph < 4 * S) ? 32'(ph / S) : 32'd0);
      if (ph == 4 * S) check("hold_start_pass", 32'(bus.pass), 32'd1);
      if (k == 2 * P - 1) bus.start = 1'b0;
    end
    @(negedge clk);
    check("hold_start_stop", 32'(bus.busy), 32'd0);

    // Reset mid-run with a failing circuit; partial results discarded
    cut_tt = 4'b1111;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    @(negedge clk);
    check_idle_zero("mid_reset_held");
    rst = 1'b0;
    run_pass(EXP, -1, fv, ps);
    check("after_reset_pass", 32'(ps), 32'd1);
    check("after_reset_fail_vec", 32'(fv), 32'd0);

    // Randomized circuits and stray start pulses against the rule model
    for (int i = 0; i < 10; i++) begin
      rtt = 4'($urandom);
      pa  = int'($urandom_range(0, 4 * S));
      run_pass(rtt, pa, fv, ps);
      check("rand_fail_vec", 32'(fv), 32'(model_fail(rtt)));
      check("rand_pass", 32'(ps), (rtt == EXP) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
